// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: main output register plus one skid register so the
// upstream ready can come straight from a flop while sustaining one word per cycle.
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [1:0]       state_dbg
);

  // Handshake: a word moves on a side only in a cycle where both valid and
  // ready are high at the rising edge; the producer holds data/valid until then.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             fire;
  logic             main_from_in;
  logic             main_from_skid;
  logic             skid_load;

  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;
  assign out_data  = main_q;
  assign state_dbg = state;

  always_comb begin
    state_nxt      = state;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      // Drops held words and any same-cycle accept; data registers stay stale.
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_from_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (accept && fire) begin
            main_from_in = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_nxt = TWO;
          end else if (fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (fire) begin
            main_from_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_from_in) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= in_data;
      end
    end
  end

  // Status outputs are decoded from the next state so they are pure flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt == ONE) || (state_nxt == TWO);
      case (state_nxt)
        ONE:     occupancy <= 2'd1;
        TWO:     occupancy <= 2'd2;
        default: occupancy <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: vector table, hand sequences for reset/stall/flush,
// and random traffic against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   occupancy;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: words held by the stage, oldest first.
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         f;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_ov;
    logic         e_ir;
    logic [1:0]   e_occ;
    logic [W-1:0] e_data;
    logic         chk_data;
  } vec_t;

  vec_t vecs[40];
  int   nvec = 0;

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply inputs for one cycle, advance the model, sample #1 after the edge.
  task automatic step(input logic f, input logic iv, input logic [W-1:0] d, input logic ordy);
    logic m_acc;
    logic m_fire;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    m_acc  = iv && (exp_q.size() < 2);
    m_fire = ordy && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (f) begin
      exp_q.delete();
    end else begin
      if (m_fire) void'(exp_q.pop_front());
      if (m_acc) exp_q.push_back(d);
    end
  endtask

  task automatic add_v(input logic f, input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic e_ov, input logic e_ir, input logic [1:0] e_occ,
                       input logic [W-1:0] e_data, input logic chk_data);
    vecs[nvec].f        = f;
    vecs[nvec].iv       = iv;
    vecs[nvec].d        = d;
    vecs[nvec].ordy     = ordy;
    vecs[nvec].e_ov     = e_ov;
    vecs[nvec].e_ir     = e_ir;
    vecs[nvec].e_occ    = e_occ;
    vecs[nvec].e_data   = e_data;
    vecs[nvec].chk_data = chk_data;
    nvec++;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_out_valid"}, out_valid, (exp_q.size() > 0));
    chk({tag, "_in_ready"}, in_ready, (exp_q.size() < 2));
    chk({tag, "_occupancy"}, occupancy, exp_q.size());
    if (exp_q.size() > 0) chk({tag, "_out_data"}, out_data, exp_q[0]);
  endtask

  initial begin
    logic [W-1:0] tx_next;
    logic [W-1:0] rx_next;
    int           n_acc;
    int           n_rx;
    int           occ_over;
    logic         iv;
    logic         ordy;

    rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_occupancy", occupancy, 2'd0);
    chk("reset_out_data", out_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming 1..8 with the consumer always ready, then drain.
    for (int k = 1; k <= 8; k++) add_v(0, 1, k, 1, 1, 1, 2'd1, k, 1);
    add_v(0, 0, 0, 1, 0, 1, 2'd0, 0, 0);
    // Backpressure: A0, A1 fill the stage, A2 is held off until space opens.
    add_v(0, 1, 32'hA0, 0, 1, 1, 2'd1, 32'hA0, 1);
    add_v(0, 1, 32'hA1, 0, 1, 0, 2'd2, 32'hA0, 1);
    add_v(0, 1, 32'hA2, 0, 1, 0, 2'd2, 32'hA0, 1);
    add_v(0, 1, 32'hA2, 1, 1, 1, 2'd1, 32'hA1, 1);
    add_v(0, 1, 32'hA2, 1, 1, 1, 2'd1, 32'hA2, 1);
    add_v(0, 0, 0, 0, 1, 1, 2'd1, 32'hA2, 1);
    add_v(0, 0, 0, 1, 0, 1, 2'd0, 0, 0);
    // Flush while full beats a same-cycle accept and fire; 0x66 follows normally.
    add_v(0, 1, 32'h11, 0, 1, 1, 2'd1, 32'h11, 1);
    add_v(0, 1, 32'h22, 0, 1, 0, 2'd2, 32'h11, 1);
    add_v(1, 1, 32'h55, 1, 0, 1, 2'd0, 0, 0);
    add_v(0, 1, 32'h66, 0, 1, 1, 2'd1, 32'h66, 1);
    add_v(0, 0, 0, 1, 0, 1, 2'd0, 0, 0);

    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
      chk($sformatf("vec%0d_occupancy", i), occupancy, vecs[i].e_occ);
      if (vecs[i].chk_data) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_data);
    end

    // Stall stability: consumer stalled for 5 cycles while in_valid toggles.
    step(0, 1, 32'hDEADBEEF, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, (i % 2 == 0), 32'h12340000 + i, 0);
      chk($sformatf("stall%0d_out_data", i), out_data, 32'hDEADBEEF);
      chk($sformatf("stall%0d_out_valid", i), out_valid, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk_model($sformatf("stall_drain%0d", i));
    end

    // Asynchronous reset while two words are held.
    step(0, 1, 32'h77, 0);
    step(0, 1, 32'h88, 0);
    chk("pre_rst_occupancy", occupancy, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_occupancy", occupancy, 2'd0);
    chk("async_rst_out_data", out_data, '0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic with an incrementing data pattern.
    tx_next  = 32'h1000;
    rx_next  = 32'h1000;
    n_acc    = 0;
    n_rx     = 0;
    occ_over = 0;
    for (int c = 0; c < 1000; c++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      if (out_valid && ordy) begin
        chk("rand_fifo_order", out_data, rx_next);
        rx_next++;
        n_rx++;
      end
      if (iv && (exp_q.size() < 2)) n_acc++;
      step(0, iv, tx_next, ordy);
      if (iv && in_ready === 1'b0 && exp_q.size() == 2 && exp_q[1] == tx_next) tx_next++;
      else if (iv && exp_q.size() > 0 && exp_q[exp_q.size()-1] == tx_next) tx_next++;
      if (occupancy > 2'd2) occ_over++;
      chk_model("rand");
    end
    for (int i = 0; i < 4; i++) begin
      if (out_valid) begin
        chk("drain_fifo_order", out_data, rx_next);
        rx_next++;
        n_rx++;
      end
      step(0, 0, 0, 1);
    end
    chk("rand_dropped_words", n_acc - n_rx, 0);
    chk("rand_occupancy_over_2", occ_over, 0);
    chk("rand_final_out_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Elastic pipeline stage register with valid/ready handshakes on both sides and a 2-entry skid buffer.
- Drop-in replacement for the plain per-stage data register wherever a downstream stage can stall.
- Accepts a word when the upstream asserts valid and this block asserts ready. Presents the word to the downstream stage and holds it until the consumer asserts ready.
- Sustains 1 word/cycle. in_ready is driven from a flop, so no combinational path runs from out_ready to in_ready.

Parameters:
WIDTH, 32, data word width in bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous discard of all held words
in_data  input  WIDTH  upstream data
in_valid  input  1  upstream word present
in_ready  output  1  block can accept a word this cycle
out_data  output  WIDTH  downstream data (main register)
out_valid  output  1  main register holds a word
out_ready  input  1  downstream consumes out_data this cycle
occupancy  output  2  words held (0, 1 or 2)

Behaviour:
- One clock: clk. Reset is asynchronous and active-high (rst).
- Reset (async assert, deassert aligned to clk):
  - state=EMPTY
  - out_valid=0, in_ready=1, occupancy=0
  - out_data=0, skid register=0
- Definitions:
  - Accept = in_valid & in_ready.
  - Fire = out_valid & out_ready.
  - All updates happen on the rising edge of clk.
- States: EMPTY (occ 0), ONE (main full, occ 1), TWO (main+skid full, occ 2).
- Registered outputs per state:
  - in_ready = 1 in EMPTY/ONE, 0 in TWO.
  - out_valid = 1 in ONE/TWO.
- EMPTY:
  - Accept -> main<=in_data, go ONE.
  - Otherwise stay EMPTY.
  - out_ready is ignored.
- ONE:
  - Accept & Fire -> main<=in_data, stay ONE.
  - Accept only -> skid<=in_data, go TWO.
  - Fire only -> go EMPTY.
  - Neither -> hold.
- TWO:
  - Fire -> main<=skid, go ONE.
  - Otherwise hold.
  - in_valid is ignored because in_ready=0.
- Latency: an accepted word is visible on out_data/out_valid the cycle after acceptance. No bypass path from in_data to out_data.
- Ordering: strict FIFO. The skid word is always older than any later accept and is never overtaken.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change.
- flush:
  - Highest priority over Accept/Fire in the same cycle. Next state is EMPTY, occupancy=0.
  - The word presented on in_data that cycle is dropped, even though in_ready=1 signalled acceptance to the upstream.
  - Data registers keep their stale contents. out_valid=0 masks them.
- Reset mid-transfer: all held words are lost immediately on rst assertion, with no completion of any in-flight handshake.
- occupancy equals 0/1/2 for EMPTY/ONE/TWO and is registered.
- Illegal state encodings recover to EMPTY.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-cycle while occupancy=2.
  - Required: out_valid=0, in_ready=1 and occupancy=0 immediately (asynchronous). out_data=0.
- Streaming:
  - Stimulus: out_ready=1 held; drive in_valid=1 with 0x00000001..0x00000008 on consecutive cycles.
  - Required: out_data shows 0x1..0x8 on consecutive cycles, each one cycle after acceptance. in_ready stays 1 throughout. occupancy stays 1 in steady state.
- Backpressure:
  - Stimulus: stream 0xA0, 0xA1, 0xA2 with out_ready=0.
  - Required: 0xA0 in main, 0xA1 in skid, occupancy=2, in_ready=0, and 0xA2 is held off by the upstream.
  - Stimulus: raise out_ready.
  - Required: output sequence is 0xA0, 0xA1, 0xA2 with no loss or duplication.
- Stall stability:
  - Stimulus: out_valid=1 with out_data=0xDEADBEEF; hold out_ready=0 for 5 cycles while in_valid toggles.
  - Required: out_data=0xDEADBEEF and out_valid=1 unchanged for all 5 cycles.
- Flush priority:
  - Stimulus: in state TWO, assert flush with in_valid=1, in_data=0x55 and out_ready=1.
  - Required: next cycle occupancy=0 and out_valid=0. 0x55 never appears on out_data.
  - Stimulus: send 0x66.
  - Required: 0x66 appears one cycle after its acceptance.
- Random:
  - Stimulus: 1000 cycles with random in_valid/out_ready at 50% each, on an incrementing data pattern.
  - Required: scoreboard shows FIFO order, a dropped-word count of zero, and occupancy never exceeding 2.
